riscv_ex2_stage: RTL and testbench
==================================

Name: riscv_ex2_stage

Overview:
Execute Stage 2 (EX2), stage 4 of 10. Sits directly upstream of EX3 and owns the whole single-cycle integer ALU: operand forwarding, ADD/SUB/logic/compare/shift evaluation, stall-bubble insertion and flush. Its registered outputs feed EX3, which passes the result through unchanged. The critical path must stay under 500 ps for 2 GHz at 7 nm.

Parameters:
XLEN, 32, datapath width (only 32 supported)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
ex1_valid  input  1  EX1 holds a valid instruction
ex1_rs1_data  input  32  register-file operand 1
ex1_rs2_data  input  32  register-file operand 2 (or immediate, pre-muxed in EX1)
ex1_rs1_addr  input  5  source 1 index (forwarding compare)
ex1_rs2_addr  input  5  source 2 index; 0 when operand 2 is an immediate
ex1_rd_addr  input  5  destination index
ex1_alu_op  input  4  ALU opcode (encoding below)
ex1_ready  output  1  EX2 accepts EX1 this cycle; combinational, equals !stall
stall  input  1  hazard unit: do not accept EX1 this cycle
flush  input  1  kill the instruction entering EX2 (branch mispredict or trap)
ex3_alu_result  input  32  EX3 result, forwarding source
ex3_rd_addr  input  5  EX3 destination
ex3_valid  input  1  EX3 valid
ex4_alu_result  input  32  EX4 result, forwarding source
ex4_rd_addr  input  5  EX4 destination
ex4_valid  input  1  EX4 valid
ex2_alu_partial  output  32  ALU result to EX3 (no reset, datapath)
ex2_rd_addr  output  5  destination to EX3 (no reset, datapath)
ex2_alu_op  output  4  opcode to EX3 (no reset, datapath)
ex2_valid  output  1  valid to EX3 (reset 0)
ex2_op_count  output  CNT_W  instructions issued to EX3 (reset 0)
ex2_bubble_count  output  CNT_W  bubbles inserted by stall (reset 0)

Behaviour:
- Opcode encoding, by alu_op[2:0]:
  - 0: ADD, or SUB when op[3]=1
  - 1: AND
  - 2: OR
  - 3: XOR
  - 4: SLT (signed), or SLTU when op[3]=1; result is 0 or 1, zero-extended
  - 5: SLL
  - 6: SRL
  - 7: SRA
  - Shift amount is op2[4:0]; upper bits ignored. ADD/SUB wrap modulo 2^32. op[3] is ignored for codes 1-3 and 5-7.
- Forwarding, evaluated per operand and combinationally. Priority order:
  1. Own output register: ex2_valid and ex2_rd_addr matches.
  2. EX3: ex3_valid and address matches.
  3. EX4: ex4_valid and address matches.
  4. Register-file data.
  - A source index of 0 never forwards; operand reads as ex1_*_data (EX1 guarantees x0 data = 0).
- Latency: 1 cycle. An accepted EX1 instruction at edge N appears on the ex2_* outputs after edge N.
- Register update at each posedge:
  - rst asserted (async, immediate): ex2_valid=0, both counters=0; data regs keep their value (not reset).
  - Else if flush: ex2_valid<=0; data regs may update; counters unchanged. Flush has priority over stall.
  - Else if stall: ex2_valid<=0 (bubble); data regs hold; ex2_bubble_count increments.
  - Else: ex2_valid<=ex1_valid; data regs load the computed result, rd and op; ex2_op_count increments only when ex1_valid=1.
- ex1_ready = !stall, regardless of flush or rst.
- No instruction is ever presented to EX3 on two consecutive cycles. Because a stall yields a bubble, EX3 needs no hold logic.
- Counters wrap at 2^CNT_W to 0 without any flag.
- Reset mid-stream: the in-flight instruction is dropped. The first valid output after reset deasserts comes from the first accepted EX1 instruction.
- Data outputs are X after reset until the first load. The bench checks them only when ex2_valid=1.

Test Plan:
- ALU sweep: rs1=0xFFFF_FFF0, rs2=0x0000_0014, no hazards. Results:
  - ADD → 0x0000_0004
  - SUB → 0xFFFF_FFDC
  - AND → 0x10
  - OR → 0xFFFF_FFF4
  - XOR → 0xFFFF_FFE4
  - SLT → 1
  - SLTU → 0
  - SLL → 0xFF00_0000
  - SRL → 0x0000_0FFF
  - SRA → 0xFFFF_FFFF
- Shift masking: SLL with rs2=0x0000_0021, rs1=1 → 0x2 (shamt=1).
- Forwarding priority:
  - ex2 output rd=5 holds 0xAAAA; EX3 rd=5 holds 0xBBBB; EX4 rd=5 holds 0xCCCC; ADD rs1=5, rs2=0 data 0 → 0xAAAA.
  - Drop ex2_valid → 0xBBBB.
  - Drop ex3_valid → 0xCCCC.
  - Same stimulus with rs1=0 → rs1_data.
- Stall: valid ADD presented while stall=1 for 3 cycles.
  - ex1_ready=0 and ex2_valid=0 for 3 cycles; ex2_bubble_count +3.
  - Released: instruction appears once; ex2_op_count +1.
- Flush with stall: flush=1 and stall=1 on the same edge → ex2_valid=0 and bubble_count unchanged; flush alone on a valid instruction → ex2_valid=0 and op_count unchanged.
- Async reset: assert rst between edges while ex2_valid=1 → ex2_valid and both counters go to 0 immediately without a clock edge.
  - Deassert rst; preload counter at 0xFFFF_FFFF and issue one instruction → op_count wraps to 0.

Source files
------------

// File: rtl/riscv_ex2_stage.sv
// riscv_ex2_stage: execute stage 2 (stage 4 of 10).
// Holds the complete single-cycle integer ALU. Operands are forwarded from
// this stage's own output register, then EX3, then EX4, else the register
// file. The registered result goes to EX3. A stall produces a bubble and a
// flush kills the instruction that is entering the stage.
//
// Handshake: EX1 -> EX2 uses valid/ready. An EX1 instruction is accepted on a
// rising edge when ex1_valid=1 and ex1_ready=1 (ex1_ready = !stall) and flush=0.
// EX2 -> EX3 carries only a valid bit. EX3 is always ready, because a
// stalled EX2 emits a bubble and never presents the same instruction twice.
module riscv_ex2_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex1_valid,
   input  logic [31:0]      ex1_rs1_data,
   input  logic [31:0]      ex1_rs2_data,
   input  logic [4:0]       ex1_rs1_addr,
   input  logic [4:0]       ex1_rs2_addr,
   input  logic [4:0]       ex1_rd_addr,
   input  logic [3:0]       ex1_alu_op,
   output logic             ex1_ready,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      ex3_alu_result,
   input  logic [4:0]       ex3_rd_addr,
   input  logic             ex3_valid,
   input  logic [31:0]      ex4_alu_result,
   input  logic [4:0]       ex4_rd_addr,
   input  logic             ex4_valid,
   output logic [31:0]      ex2_alu_partial,
   output logic [4:0]       ex2_rd_addr,
   output logic [3:0]       ex2_alu_op,
   output logic             ex2_valid,
   output logic [CNT_W-1:0] ex2_op_count,
   output logic [CNT_W-1:0] ex2_bubble_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic [4:0]      shamt;
   logic            lt;

   // Acceptance depends only on the hazard unit. Flush and reset do not affect it.
   assign ex1_ready = !stall;

   // Operand 1 forwarding: own output, then EX3, then EX4, else register file. x0 never forwards.
   always_comb begin
      op_a = ex1_rs1_data;
      if (ex1_rs1_addr != 5'd0) begin
         if (ex2_valid && (ex2_rd_addr == ex1_rs1_addr))
            op_a = ex2_alu_partial;
         else if (ex3_valid && (ex3_rd_addr == ex1_rs1_addr))
            op_a = ex3_alu_result;
         else if (ex4_valid && (ex4_rd_addr == ex1_rs1_addr))
            op_a = ex4_alu_result;
      end
   end

   // Operand 2 forwarding, same priority. Address 0 also covers immediates.
   always_comb begin
      op_b = ex1_rs2_data;
      if (ex1_rs2_addr != 5'd0) begin
         if (ex2_valid && (ex2_rd_addr == ex1_rs2_addr))
            op_b = ex2_alu_partial;
         else if (ex3_valid && (ex3_rd_addr == ex1_rs2_addr))
            op_b = ex3_alu_result;
         else if (ex4_valid && (ex4_rd_addr == ex1_rs2_addr))
            op_b = ex4_alu_result;
      end
   end

   // ALU evaluation. op[3] selects SUB and SLTU and is ignored for every other code.
   always_comb begin
      shamt   = op_b[4:0];
      lt      = ex1_alu_op[3] ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
      alu_res = '0;
      case (ex1_alu_op[2:0])
         3'd0:    alu_res = ex1_alu_op[3] ? (op_a - op_b) : (op_a + op_b);
         3'd1:    alu_res = op_a & op_b;
         3'd2:    alu_res = op_a | op_b;
         3'd3:    alu_res = op_a ^ op_b;
         3'd4:    alu_res = {{(XLEN-1){1'b0}}, lt};
         3'd5:    alu_res = op_a << shamt;
         3'd6:    alu_res = op_a >> shamt;
         3'd7:    alu_res = $signed(op_a) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // Control state: valid bit and counters. Flush wins over stall, and a stall emits a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex2_valid        <= 1'b0;
         ex2_op_count     <= '0;
         ex2_bubble_count <= '0;
      end else if (flush) begin
         ex2_valid <= 1'b0;
      end else if (stall) begin
         ex2_valid        <= 1'b0;
         ex2_bubble_count <= ex2_bubble_count + CNT_ONE;
      end else begin
         ex2_valid <= ex1_valid;
         if (ex1_valid)
            ex2_op_count <= ex2_op_count + CNT_ONE;
      end
   end

   // Datapath registers have no reset. They load whenever the stage is not stalled.
   always_ff @(posedge clk) begin
      if (!stall) begin
         ex2_alu_partial <= alu_res;
         ex2_rd_addr     <= ex1_rd_addr;
         ex2_alu_op      <= ex1_alu_op;
      end
   end

endmodule

// File: tb/tb_riscv_ex2_stage.sv
// tb_riscv_ex2_stage: directed test of the EX2 ALU stage. It uses a table-driven
// ALU sweep plus hand-written forwarding, stall, flush and reset sequences.
module tb_riscv_ex2_stage;

   logic        clk;
   logic        rst;
   logic        ex1_valid;
   logic [31:0] ex1_rs1_data;
   logic [31:0] ex1_rs2_data;
   logic [4:0]  ex1_rs1_addr;
   logic [4:0]  ex1_rs2_addr;
   logic [4:0]  ex1_rd_addr;
   logic [3:0]  ex1_alu_op;
   logic        ex1_ready;
   logic        stall;
   logic        flush;
   logic [31:0] ex3_alu_result;
   logic [4:0]  ex3_rd_addr;
   logic        ex3_valid;
   logic [31:0] ex4_alu_result;
   logic [4:0]  ex4_rd_addr;
   logic        ex4_valid;
   logic [31:0] ex2_alu_partial;
   logic [4:0]  ex2_rd_addr;
   logic [3:0]  ex2_alu_op;
   logic        ex2_valid;
   logic [31:0] ex2_op_count;
   logic [31:0] ex2_bubble_count;

   // Narrow-counter instance: it shares every input and is used to observe counter wrap.
   logic        s_ready;
   logic [31:0] s_alu_partial;
   logic [4:0]  s_rd_addr;
   logic [3:0]  s_alu_op;
   logic        s_valid;
   logic [3:0]  s_op_count;
   logic [3:0]  s_bubble_count;

   int n_checks;
   int n_fail;

   // Reference model of the control state.
   logic        exp_valid;
   logic [31:0] exp_ops;
   logic [31:0] exp_bub;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[14];

   riscv_ex2_stage #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ex1_valid(ex1_valid),
      .ex1_rs1_data(ex1_rs1_data), .ex1_rs2_data(ex1_rs2_data),
      .ex1_rs1_addr(ex1_rs1_addr), .ex1_rs2_addr(ex1_rs2_addr),
      .ex1_rd_addr(ex1_rd_addr), .ex1_alu_op(ex1_alu_op), .ex1_ready(ex1_ready),
      .stall(stall), .flush(flush),
      .ex3_alu_result(ex3_alu_result), .ex3_rd_addr(ex3_rd_addr), .ex3_valid(ex3_valid),
      .ex4_alu_result(ex4_alu_result), .ex4_rd_addr(ex4_rd_addr), .ex4_valid(ex4_valid),
      .ex2_alu_partial(ex2_alu_partial), .ex2_rd_addr(ex2_rd_addr),
      .ex2_alu_op(ex2_alu_op), .ex2_valid(ex2_valid),
      .ex2_op_count(ex2_op_count), .ex2_bubble_count(ex2_bubble_count)
   );

   riscv_ex2_stage #(.XLEN(32), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .ex1_valid(ex1_valid),
      .ex1_rs1_data(ex1_rs1_data), .ex1_rs2_data(ex1_rs2_data),
      .ex1_rs1_addr(ex1_rs1_addr), .ex1_rs2_addr(ex1_rs2_addr),
      .ex1_rd_addr(ex1_rd_addr), .ex1_alu_op(ex1_alu_op), .ex1_ready(s_ready),
      .stall(stall), .flush(flush),
      .ex3_alu_result(ex3_alu_result), .ex3_rd_addr(ex3_rd_addr), .ex3_valid(ex3_valid),
      .ex4_alu_result(ex4_alu_result), .ex4_rd_addr(ex4_rd_addr), .ex4_valid(ex4_valid),
      .ex2_alu_partial(s_alu_partial), .ex2_rd_addr(s_rd_addr),
      .ex2_alu_op(s_alu_op), .ex2_valid(s_valid),
      .ex2_op_count(s_op_count), .ex2_bubble_count(s_bubble_count)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Update the model from the current inputs, clock one edge, then compare the control outputs.
   task automatic step();
      if (rst) begin
         exp_valid = 1'b0;
         exp_ops   = '0;
         exp_bub   = '0;
      end else if (flush) begin
         exp_valid = 1'b0;
      end else if (stall) begin
         exp_valid = 1'b0;
         exp_bub   = exp_bub + 32'd1;
      end else begin
         exp_valid = ex1_valid;
         if (ex1_valid) exp_ops = exp_ops + 32'd1;
      end
      @(posedge clk);
      #1;
      check("ex2_valid", {31'b0, ex2_valid}, {31'b0, exp_valid});
      check("op_count", ex2_op_count, exp_ops);
      check("bubble_count", ex2_bubble_count, exp_bub);
      check("op_count_w4", {28'b0, s_op_count}, {28'b0, exp_ops[3:0]});
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] a_addr, input logic [31:0] a,
                        input logic [4:0] b_addr, input logic [31:0] b, input logic [4:0] rd);
      ex1_valid    = 1'b1;
      ex1_alu_op   = op;
      ex1_rs1_addr = a_addr;
      ex1_rs1_data = a;
      ex1_rs2_addr = b_addr;
      ex1_rs2_data = b;
      ex1_rd_addr  = rd;
      step();
   endtask

   task automatic idle();
      ex1_valid = 1'b0;
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_valid = 1'b0;
      exp_ops   = '0;
      exp_bub   = '0;

      // Opcodes: ADD 0, SUB 8, AND 1, OR 2, XOR 3, SLT 4, SLTU 12, SLL 5, SRL 6, SRA 7.
      vecs[0]  = '{4'h0, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0004};
      vecs[1]  = '{4'h8, 32'hFFFF_FFF0, 32'h0000_0014, 32'hFFFF_FFDC};
      vecs[2]  = '{4'h1, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0010};
      vecs[3]  = '{4'h2, 32'hFFFF_FFF0, 32'h0000_0014, 32'hFFFF_FFF4};
      vecs[4]  = '{4'h3, 32'hFFFF_FFF0, 32'h0000_0014, 32'hFFFF_FFE4};
      vecs[5]  = '{4'h4, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0001};
      vecs[6]  = '{4'hC, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0000};
      vecs[7]  = '{4'h5, 32'hFFFF_FFF0, 32'h0000_0014, 32'hFF00_0000};
      vecs[8]  = '{4'h6, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0FFF};
      vecs[9]  = '{4'h7, 32'hFFFF_FFF0, 32'h0000_0014, 32'hFFFF_FFFF};
      vecs[10] = '{4'h5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
      vecs[11] = '{4'hE, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0FFF};
      vecs[12] = '{4'h9, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0010};
      vecs[13] = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};

      // Reset with all inputs quiet.
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      ex1_valid = 1'b0; ex1_rs1_data = '0; ex1_rs2_data = '0;
      ex1_rs1_addr = '0; ex1_rs2_addr = '0; ex1_rd_addr = '0; ex1_alu_op = '0;
      ex3_alu_result = '0; ex3_rd_addr = '0; ex3_valid = 1'b0;
      ex4_alu_result = '0; ex4_rd_addr = '0; ex4_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("ex1_ready_idle", {31'b0, ex1_ready}, 32'd1);

      // ALU sweep without hazards. rd=3 never matches the sources 1 and 2.
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].op, 5'd1, vecs[i].a, 5'd2, vecs[i].b, 5'd3);
         check($sformatf("alu_res[%0d]", i), ex2_alu_partial, vecs[i].res);
         check($sformatf("alu_op[%0d]", i), {28'b0, ex2_alu_op}, {28'b0, vecs[i].op});
         check($sformatf("rd[%0d]", i), {27'b0, ex2_rd_addr}, 32'd3);
      end
      idle();

      // Forwarding priority: own output, then EX3, then EX4.
      issue(4'h0, 5'd1, 32'h0000_AAAA, 5'd0, 32'h0, 5'd5);
      check("fwd_setup", ex2_alu_partial, 32'h0000_AAAA);
      ex3_alu_result = 32'h0000_BBBB; ex3_rd_addr = 5'd5; ex3_valid = 1'b1;
      ex4_alu_result = 32'h0000_CCCC; ex4_rd_addr = 5'd5; ex4_valid = 1'b1;
      issue(4'h0, 5'd5, 32'h0000_1111, 5'd0, 32'h0, 5'd6);
      check("fwd_ex2", ex2_alu_partial, 32'h0000_AAAA);
      idle();
      issue(4'h0, 5'd5, 32'h0000_1111, 5'd0, 32'h0, 5'd6);
      check("fwd_ex3", ex2_alu_partial, 32'h0000_BBBB);
      ex3_valid = 1'b0;
      idle();
      issue(4'h0, 5'd5, 32'h0000_1111, 5'd0, 32'h0, 5'd6);
      check("fwd_ex4", ex2_alu_partial, 32'h0000_CCCC);
      issue(4'h0, 5'd0, 32'h0000_1111, 5'd0, 32'h0, 5'd6);
      check("fwd_rs1_x0", ex2_alu_partial, 32'h0000_1111);

      // x0 never forwards, even when every stage targets x0.
      ex3_rd_addr = 5'd0; ex3_valid = 1'b1; ex4_rd_addr = 5'd0;
      issue(4'h0, 5'd1, 32'h0000_AAAA, 5'd2, 32'h0, 5'd0);
      issue(4'h0, 5'd0, 32'h0000_1111, 5'd0, 32'h0, 5'd6);
      check("fwd_x0_all", ex2_alu_partial, 32'h0000_1111);

      // Operand 2 forwarding from EX3.
      ex3_alu_result = 32'h0000_0100; ex3_rd_addr = 5'd7; ex3_valid = 1'b1; ex4_valid = 1'b0;
      issue(4'h8, 5'd1, 32'h0000_0300, 5'd7, 32'h0000_0999, 5'd8);
      check("fwd_op2_ex3", ex2_alu_partial, 32'h0000_0200);
      ex3_valid = 1'b0;

      // Stall for three cycles with a valid ADD waiting.
      ex1_valid = 1'b1; ex1_alu_op = 4'h0; ex1_rs1_addr = 5'd1; ex1_rs1_data = 32'd40;
      ex1_rs2_addr = 5'd2; ex1_rs2_data = 32'd2; ex1_rd_addr = 5'd9;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ex1_ready_stall", {31'b0, ex1_ready}, 32'd0);
         step();
      end
      stall = 1'b0;
      #1;
      check("ex1_ready_release", {31'b0, ex1_ready}, 32'd1);
      step();
      check("stall_release_res", ex2_alu_partial, 32'd42);
      check("stall_release_rd", {27'b0, ex2_rd_addr}, 32'd9);
      idle();

      // Flush and stall on the same edge: no bubble is counted.
      ex1_valid = 1'b1; flush = 1'b1; stall = 1'b1;
      step();
      // Flush alone on a valid instruction: no op is counted, and ready stays high.
      stall = 1'b0;
      #1;
      check("ex1_ready_flush", {31'b0, ex1_ready}, 32'd1);
      step();
      flush = 1'b0;
      issue(4'h3, 5'd1, 32'h0000_00FF, 5'd2, 32'h0000_000F, 5'd4);
      check("post_flush_res", ex2_alu_partial, 32'h0000_00F0);

      // Asynchronous reset between edges while ex2_valid=1.
      #3;
      rst = 1'b1;
      #1;
      check("async_valid", {31'b0, ex2_valid}, 32'd0);
      check("async_ops", ex2_op_count, 32'd0);
      check("async_bub", ex2_bubble_count, 32'd0);
      exp_valid = 1'b0; exp_ops = '0; exp_bub = '0;
      step();
      rst = 1'b0;
      idle();

      // After reset the first valid output comes from the first accepted instruction.
      // Sixteen issues wrap the 4-bit counter back to 0.
      issue(4'h0, 5'd1, 32'd7, 5'd2, 32'd8, 5'd10);
      check("post_reset_res", ex2_alu_partial, 32'd15);
      for (int i = 1; i < 16; i++) begin
         issue(4'h0, 5'd1, 32'd7, 5'd2, 32'd8, 5'd10);
      end
      check("wrap_w4", {28'b0, s_op_count}, 32'd0);
      check("ops_w32_16", ex2_op_count, 32'd16);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
